mips_reg_writeback: RTL and testbench
=====================================

// Module: mips_reg_writeback
// PURPOSE
//   Write-side initiator for the MIPS register file. It buffers datapath results in a FIFO and drains them
//   into the register file write port (write_data, write_reg, signal_reg_write), at most one write per clock.
//   It discards writes to $0 and can forward still-pending results to the operand readers.
//   Sits between the ALU/memory result mux and mips_registers.
// PARAMETERS
//   DEPTH   4   FIFO entries; power of two, >= 2
//   DATA_W  32  result/register data width
//   ADDR_W  5   register index width
// PORTS
//   clk              in   1       system clock; all state updates on posedge
//   rst_n            in   1       asynchronous, active-low reset
//   in_valid         in   1       result offered by datapath
//   in_ready         out  1       FIFO can accept; equals !full (combinational from count)
//   in_reg           in   ADDR_W  destination register of offered result
//   in_data          in   DATA_W  offered result value
//   drain_en         in   1       1 = register-file write port available this cycle
//   write_data       out  DATA_W  to register file write_data
//   write_reg        out  ADDR_W  to register file write_reg
//   signal_reg_write out  1       to register file signal_reg_write; 1-cycle pulse per write
//   rd_reg_1         in   ADDR_W  operand-1 register being read
//   rd_reg_2         in   ADDR_W  operand-2 register being read
//   byp_hit_1        out  1       rd_reg_1 has an uncommitted pending write
//   byp_data_1       out  DATA_W  youngest pending value for rd_reg_1 (0 when no hit)
//   byp_hit_2        out  1       same for rd_reg_2
//   byp_data_2       out  DATA_W  same for rd_reg_2
//   count            out  clog2(DEPTH)+1  FIFO occupancy
//   idle             out  1       count==0 && !signal_reg_write
// BEHAVIOUR
//   Reset (rst_n low, asynchronous): pointers=0, count=0, signal_reg_write=0, write_reg=0, write_data=0.
//     Consequently in_ready=1, idle=1, byp_hit_*=0, byp_data_*=0. Pending entries are dropped, including mid-drain.
//   Push: on posedge, if in_valid && in_ready && in_reg!=0, write {in_reg,in_data} at wptr and advance wptr.
//     in_reg==0 is accepted (handshake completes) and discarded.
//   Pop: on posedge, if drain_en && count!=0, load head into write_reg/write_data, set signal_reg_write=1,
//     and advance rptr. Otherwise signal_reg_write=0 and write_reg/write_data hold their values.
//   Timing: the register file commits a write on the negedge following the posedge that raised signal_reg_write.
//   Latency: with an empty FIFO and drain_en=1, a result accepted at edge N is presented after edge N+1.
//   Simultaneous push+pop: both occur and count is unchanged. When full, in_ready=0 even if a pop happens
//     in the same cycle (no pass-through).
//   Pointers wrap modulo DEPTH. count = pushes - pops; it never exceeds DEPTH and never goes below 0.
//   Order: writes reach the register file in acceptance order. Same-register writes are all performed
//     (no merging).
//   Bypass (combinational): search valid FIFO entries youngest to oldest, then the output stage if
//     signal_reg_write=1. The first match on rd_reg_x gives hit=1 and its data.
//     rd_reg_x==0 always gives hit=0, data=0.
// CONFIGURATION
//   MIPS_WB_BYPASS_EN defined: the bypass comparators are built as described above.
//   Not defined: byp_hit_* and byp_data_* are tied to 0 and no comparators are synthesised. Ports remain.
//     The datapath must then stall on !idle before reading.
// TESTING
//   1. rst_n=0 asserted asynchronously while count=3 and signal_reg_write=1 -> immediately
//      signal_reg_write=0, count=0, in_ready=1, idle=1.
//   2. Push r5=0xDEADBEEF with drain_en=1 -> next cycle signal_reg_write=1, write_reg=5,
//      write_data=0xDEADBEEF for exactly 1 cycle. Reading r5 afterwards returns 0xDEADBEEF.
//   3. drain_en=0, push r1..r4 -> count=4 and in_ready=0. A 5th push is not accepted. Then drain_en=1 ->
//      writes r1,r2,r3,r4 on 4 consecutive cycles, count returns to 0 and idle=1.
//   4. Push r0=0x12345678 -> handshake completes, count stays 0, signal_reg_write never asserts.
//   5. BYPASS_EN, drain_en=0, push r7=0x11 then r7=0x22, rd_reg_1=7, rd_reg_2=0 -> byp_hit_1=1,
//      byp_data_1=0x22, byp_hit_2=0. After both drain, byp_hit_1=0.
//   6. BYPASS_EN not defined, same stimulus as 5 -> byp_hit_1=0, byp_data_1=0. Register file ends
//      with r7=0x22.

Source files
------------

// File: rtl/mips_reg_writeback.sv
// +-----------------------------------------------------------------------------+
// | mips_reg_writeback : FIFO-buffered write initiator for the MIPS register    |
// | file, with optional pending-write forwarding (macro MIPS_WB_BYPASS_EN).     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mips_reg_writeback #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_reg,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       drain_en,
   output logic [DATA_W-1:0]          write_data,
   output logic [ADDR_W-1:0]          write_reg,
   output logic                       signal_reg_write,
   input  logic [ADDR_W-1:0]          rd_reg_1,
   input  logic [ADDR_W-1:0]          rd_reg_2,
   output logic                       byp_hit_1,
   output logic [DATA_W-1:0]          byp_data_1,
   output logic                       byp_hit_2,
   output logic [DATA_W-1:0]          byp_data_2,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       idle
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_mem_reg  [DEPTH];
   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_full;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;

   // No pass-through: a full FIFO refuses even when a pop happens this cycle.
   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign in_ready = !w_full;
   assign w_accept = in_valid && in_ready;
   assign w_push   = w_accept && (in_reg != '0);
   assign w_pop    = drain_en && (r_count != '0);
   assign count    = r_count;
   assign idle     = (r_count == '0) && !signal_reg_write;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_reg[r_wptr]  <= in_reg;
         r_mem_data[r_wptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Output stage holds the last write; only the strobe drops when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         signal_reg_write <= 1'b0;
         write_reg        <= '0;
         write_data       <= '0;
      end else if (w_pop) begin
         signal_reg_write <= 1'b1;
         write_reg        <= r_mem_reg[r_rptr];
         write_data       <= r_mem_data[r_rptr];
      end else begin
         signal_reg_write <= 1'b0;
      end
   end

`ifdef MIPS_WB_BYPASS_EN
   for (genvar p = 0; p < 2; p++) begin : g_byp
      logic [ADDR_W-1:0] w_rd;
      logic              w_hit;
      logic [DATA_W-1:0] w_data;
      assign w_rd = (p == 0) ? rd_reg_1 : rd_reg_2;

      // Oldest source first so younger matches overwrite: output stage, then FIFO head..tail.
      always_comb begin
         logic [PTR_W-1:0] idx;
         idx    = '0;
         w_hit  = 1'b0;
         w_data = '0;
         if (signal_reg_write && (write_reg == w_rd)) begin
            w_hit  = 1'b1;
            w_data = write_data;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = r_rptr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_mem_reg[idx] == w_rd)) begin
               w_hit  = 1'b1;
               w_data = r_mem_data[idx];
            end
         end
         if (w_rd == '0) begin
            w_hit  = 1'b0;
            w_data = '0;
         end
      end
   end

   assign byp_hit_1  = g_byp[0].w_hit;
   assign byp_data_1 = g_byp[0].w_data;
   assign byp_hit_2  = g_byp[1].w_hit;
   assign byp_data_2 = g_byp[1].w_data;
`else
   logic w_unused_rd;
   assign w_unused_rd = ^{rd_reg_1, rd_reg_2};
   assign byp_hit_1   = 1'b0;
   assign byp_data_1  = '0;
   assign byp_hit_2   = 1'b0;
   assign byp_data_2  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_reg_writeback.sv
// +-----------------------------------------------------------------------------+
// | tb_mips_reg_writeback : directed vector bench for mips_reg_writeback with a |
// | negedge-committing register file model. Revision: 1.0                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mips_reg_writeback;

`ifdef MIPS_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_reg = '0;
   logic [31:0] in_data = '0;
   logic        drain_en = 1'b0;
   logic [31:0] write_data;
   logic [4:0]  write_reg;
   logic        signal_reg_write;
   logic [4:0]  rd_reg_1 = '0;
   logic [4:0]  rd_reg_2 = '0;
   logic        byp_hit_1, byp_hit_2;
   logic [31:0] byp_data_1, byp_data_2;
   logic [2:0]  count;
   logic        idle;

   int total = 0;
   int bad   = 0;

   logic [31:0] rf [32];

   mips_reg_writeback #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
      .write_data(write_data), .write_reg(write_reg), .signal_reg_write(signal_reg_write),
      .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2),
      .byp_hit_1(byp_hit_1), .byp_data_1(byp_data_1),
      .byp_hit_2(byp_hit_2), .byp_data_2(byp_data_2),
      .count(count), .idle(idle)
   );

   always #5 clk = ~clk;

   // Register file model: commits on the negedge after the strobe rises.
   initial for (int k = 0; k < 32; k++) rf[k] = '0;
   always @(negedge clk) if (signal_reg_write && write_reg != 0) rf[write_reg] <= write_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        v;
      logic [4:0]  r;
      logic [31:0] d;
      logic        drain;
      logic        e_ready;
      logic        e_srw;
      logic [4:0]  e_wreg;
      logic [31:0] e_wdata;
      logic [2:0]  e_count;
   } vec_t;

   function automatic vec_t mk(logic v, logic [4:0] r, logic [31:0] d, logic drain, logic e_ready,
                               logic e_srw, logic [4:0] e_wreg, logic [31:0] e_wdata, logic [2:0] e_count);
      vec_t t;
      t.v = v; t.r = r; t.d = d; t.drain = drain; t.e_ready = e_ready;
      t.e_srw = e_srw; t.e_wreg = e_wreg; t.e_wdata = e_wdata; t.e_count = e_count;
      return t;
   endfunction

   vec_t vecs [28];

   initial begin
      // single write, latency and hold
      vecs[0]  = mk(1, 5, 32'hDEADBEEF, 1, 1, 0, 0, 32'h0, 1);
      vecs[1]  = mk(0, 0, 32'h0,        1, 1, 1, 5, 32'hDEADBEEF, 0);
      vecs[2]  = mk(0, 0, 32'h0,        1, 1, 0, 5, 32'hDEADBEEF, 0);
      // fill to full, rejected 5th push, then drain in order
      vecs[3]  = mk(1, 1, 32'h101, 0, 1, 0, 5, 32'hDEADBEEF, 1);
      vecs[4]  = mk(1, 2, 32'h202, 0, 1, 0, 5, 32'hDEADBEEF, 2);
      vecs[5]  = mk(1, 3, 32'h303, 0, 1, 0, 5, 32'hDEADBEEF, 3);
      vecs[6]  = mk(1, 4, 32'h404, 0, 1, 0, 5, 32'hDEADBEEF, 4);
      vecs[7]  = mk(1, 9, 32'h999, 0, 0, 0, 5, 32'hDEADBEEF, 4);
      vecs[8]  = mk(0, 0, 32'h0,   1, 0, 1, 1, 32'h101, 3);
      vecs[9]  = mk(0, 0, 32'h0,   1, 1, 1, 2, 32'h202, 2);
      vecs[10] = mk(0, 0, 32'h0,   1, 1, 1, 3, 32'h303, 1);
      vecs[11] = mk(0, 0, 32'h0,   1, 1, 1, 4, 32'h404, 0);
      vecs[12] = mk(0, 0, 32'h0,   1, 1, 0, 4, 32'h404, 0);
      // write to $0 is accepted and dropped
      vecs[13] = mk(1, 0, 32'h12345678, 1, 1, 0, 4, 32'h404, 0);
      vecs[14] = mk(0, 0, 32'h0,        1, 1, 0, 4, 32'h404, 0);
      // simultaneous push and pop
      vecs[15] = mk(1, 6, 32'h66, 1, 1, 0, 4, 32'h404, 1);
      vecs[16] = mk(1, 8, 32'h88, 1, 1, 1, 6, 32'h66, 1);
      vecs[17] = mk(0, 0, 32'h0,  1, 1, 1, 8, 32'h88, 0);
      vecs[18] = mk(0, 0, 32'h0,  1, 1, 0, 8, 32'h88, 0);
      // full with concurrent pop: push refused
      vecs[19] = mk(1, 10, 32'hA0, 0, 1, 0, 8, 32'h88, 1);
      vecs[20] = mk(1, 11, 32'hB0, 0, 1, 0, 8, 32'h88, 2);
      vecs[21] = mk(1, 12, 32'hC0, 0, 1, 0, 8, 32'h88, 3);
      vecs[22] = mk(1, 13, 32'hD0, 0, 1, 0, 8, 32'h88, 4);
      vecs[23] = mk(1, 14, 32'hE0, 1, 0, 1, 10, 32'hA0, 3);
      vecs[24] = mk(0, 0, 32'h0,   1, 1, 1, 11, 32'hB0, 2);
      vecs[25] = mk(0, 0, 32'h0,   1, 1, 1, 12, 32'hC0, 1);
      vecs[26] = mk(0, 0, 32'h0,   1, 1, 1, 13, 32'hD0, 0);
      vecs[27] = mk(0, 0, 32'h0,   1, 1, 0, 13, 32'hD0, 0);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_srw",   {31'd0, signal_reg_write}, 32'd0);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_idle",  {31'd0, idle}, 32'd1);
      chk("rst_wreg",  {27'd0, write_reg}, 32'd0);
      chk("rst_wdata", write_data, 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 28; i++) begin
         in_valid = vecs[i].v;
         in_reg   = vecs[i].r;
         in_data  = vecs[i].d;
         drain_en = vecs[i].drain;
         #1;
         chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ready});
         tick();
         chk($sformatf("v%0d_srw", i),   {31'd0, signal_reg_write}, {31'd0, vecs[i].e_srw});
         chk($sformatf("v%0d_wreg", i),  {27'd0, write_reg}, {27'd0, vecs[i].e_wreg});
         chk($sformatf("v%0d_wdata", i), write_data, vecs[i].e_wdata);
         chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vecs[i].e_count});
         chk($sformatf("v%0d_idle", i),  {31'd0, idle},
             {31'd0, (vecs[i].e_count == 0) && !vecs[i].e_srw});
      end
      in_valid = 1'b0;
      tick();
      chk("rf_r5",  rf[5],  32'hDEADBEEF);
      chk("rf_r1",  rf[1],  32'h101);
      chk("rf_r4",  rf[4],  32'h404);
      chk("rf_r6",  rf[6],  32'h66);
      chk("rf_r8",  rf[8],  32'h88);
      chk("rf_r13", rf[13], 32'hD0);
      chk("rf_r9",  rf[9],  32'h0);
      chk("rf_r14", rf[14], 32'h0);

      // asynchronous reset mid-drain with count=3
      drain_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_reg = 5'(20 + i); in_data = 32'h2000 + i;
         tick();
      end
      in_valid = 1'b0; drain_en = 1'b1;
      tick();
      chk("pre_rst_srw",   {31'd0, signal_reg_write}, 32'd1);
      chk("pre_rst_count", {29'd0, count}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_srw",   {31'd0, signal_reg_write}, 32'd0);
      chk("arst_count", {29'd0, count}, 32'd0);
      chk("arst_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_idle",  {31'd0, idle}, 32'd1);
      chk("arst_wreg",  {27'd0, write_reg}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_srw",   {31'd0, signal_reg_write}, 32'd0);
      chk("post_rst_count", {29'd0, count}, 32'd0);
      chk("rf_r21", rf[21], 32'h0);

      // same-register writes and bypass
      drain_en = 1'b0;
      in_valid = 1'b1; in_reg = 5'd7; in_data = 32'h11;
      tick();
      in_data = 32'h22;
      tick();
      in_valid = 1'b0; rd_reg_1 = 5'd7; rd_reg_2 = 5'd0;
      #1;
      chk("byp_fifo_hit1",  {31'd0, byp_hit_1}, {31'd0, BYP});
      chk("byp_fifo_data1", byp_data_1, BYP ? 32'h22 : 32'h0);
      chk("byp_fifo_hit2",  {31'd0, byp_hit_2}, 32'd0);
      chk("byp_fifo_data2", byp_data_2, 32'h0);
      drain_en = 1'b1;
      tick();
      chk("r7_first_data",  write_data, 32'h11);
      chk("byp_mix_data1",  byp_data_1, BYP ? 32'h22 : 32'h0);
      tick();
      chk("r7_second_data", write_data, 32'h22);
      chk("byp_out_hit1",   {31'd0, byp_hit_1}, {31'd0, BYP});
      chk("byp_out_data1",  byp_data_1, BYP ? 32'h22 : 32'h0);
      tick();
      chk("byp_done_hit1",  {31'd0, byp_hit_1}, 32'd0);
      chk("byp_done_data1", byp_data_1, 32'h0);
      chk("done_idle",      {31'd0, idle}, 32'd1);
      chk("rf_r7",          rf[7], 32'h22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
